multi_debounce: RTL

- Parametrised N-channel successor to the single-button debouncer.
- Each channel synchronises a raw push-button input and produces a debounced level, a one-cycle press pulse and a one-cycle release pulse.
- Each channel enforces an independent lockout window after every accepted edge, so both press and release bounce are suppressed.
- Sits between board buttons and control FSMs; all channels share one clock and reset.

---
 rtl/multi_debounce.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/multi_debounce.sv
// multi_debounce: N-channel push-button debouncer.
// Every channel has a two-flop synchroniser and a four-state lockout FSM.
// Each FSM drives a debounced level and one-cycle press/release pulses.
// The optional auto-repeat is enabled by defining MULTI_DEBOUNCE_AUTO_REPEAT_EN.
// When the macro is undefined, the repeat counters and the REPEAT_* parameters
// are not present in the design at all.
// `release` is a reserved word in SystemVerilog, so the release pulse port is
// named release_pulse.
module multi_debounce #(
  parameter int CHANNELS       = 4,
  parameter int LOCKOUT_CYCLES = 20000000
`ifdef MULTI_DEBOUNCE_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY   = 50000000,
  parameter int REPEAT_PERIOD  = 10000000
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse
);

  localparam int CW = $clog2(LOCKOUT_CYCLES + 1);
  // Last count value of a lockout window: cnt runs 0..LOCKOUT_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCKOUT_CYCLES - 1);

`ifdef MULTI_DEBOUNCE_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    LOCK_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    LOCK_RELEASE = 2'd3
  } state_t;

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;

  // Two-flop synchroniser for all raw button inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      state_t        state, state_next;
      logic [CW-1:0] cnt, cnt_next;
      logic          level_reg, level_next;
      logic          press_reg, press_next;
      logic          release_reg, release_next;
`ifdef MULTI_DEBOUNCE_AUTO_REPEAT_EN
      logic [RW-1:0] rcnt, rcnt_next;
      logic          repeating, repeating_next;
`endif

      // Per-channel state, lockout counter and registered outputs.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state       <= IDLE;
          cnt         <= '0;
          level_reg   <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
`ifdef MULTI_DEBOUNCE_AUTO_REPEAT_EN
          rcnt        <= '0;
          repeating   <= 1'b0;
`endif
        end else begin
          state       <= state_next;
          cnt         <= cnt_next;
          level_reg   <= level_next;
          press_reg   <= press_next;
          release_reg <= release_next;
`ifdef MULTI_DEBOUNCE_AUTO_REPEAT_EN
          rcnt        <= rcnt_next;
          repeating   <= repeating_next;
`endif
        end
      end

      // Next-state logic: accept an edge, then ignore the input for the lockout window.
      always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        level_next   = level_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
`ifdef MULTI_DEBOUNCE_AUTO_REPEAT_EN
        // The repeat counter is held at zero outside PRESSED, so it restarts on every entry.
        rcnt_next      = '0;
        repeating_next = 1'b0;
`endif
        case (state)
          IDLE: begin
            if (sync2[gi]) begin
              state_next = LOCK_PRESS;
              press_next = 1'b1;
              level_next = 1'b1;
              cnt_next   = '0;
            end
          end
          LOCK_PRESS: begin
            if (cnt == CNT_LAST) begin
              state_next = PRESSED;
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end
          PRESSED: begin
            if (!sync2[gi]) begin
              // A release takes priority over a repeat that would have fired on this cycle.
              state_next   = LOCK_RELEASE;
              release_next = 1'b1;
              level_next   = 1'b0;
              cnt_next     = '0;
            end
`ifdef MULTI_DEBOUNCE_AUTO_REPEAT_EN
            else if (rcnt == (repeating ? PERIOD_LAST : DELAY_LAST)) begin
              press_next     = 1'b1;
              rcnt_next      = '0;
              repeating_next = 1'b1;
            end else begin
              rcnt_next      = rcnt + RW'(1);
              repeating_next = repeating;
            end
`endif
          end
          LOCK_RELEASE: begin
            if (cnt == CNT_LAST) begin
              state_next = IDLE;
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end
          default: begin
            state_next = IDLE;
          end
        endcase
      end

      assign level[gi]         = level_reg;
      assign press[gi]         = press_reg;
      assign release_pulse[gi] = release_reg;
    end
  endgenerate

endmodule
